// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared pipeline encodings for the hazard controller
package hazard_controller_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_forward_select.sv
// rtl/hazard_controller_forward_select.sv - per-operand bypass select, Memory stage wins over Writeback
module forward_select
    import hazard_controller_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard unit: forwarding, load-use stall, branch flush, multi-cycle op wait
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 34,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic             MdErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int OP_W = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(MD_MAX_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [OP_W-1:0]  op_cnt_q, op_cnt_d;
    logic             md_err_q, md_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             lw_stall;

    forward_select u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (ForwardAE)
    );

    forward_select u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (ForwardBE)
    );

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            op_cnt_q    <= '0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_cnt_q    <= op_cnt_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        md_err_d    = md_err_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (MdStartE && !MdDoneE) begin
                    state_d  = ST_MD_WAIT;
                    op_cnt_d = '0;
                end
            end
            ST_MD_WAIT: begin
                op_cnt_d = op_cnt_q + 1'b1;
                if (MdDoneE) begin
                    state_d = ST_RUN;
                end else if (op_cnt_q == OP_LAST) begin
                    // Give up on the op; the error stays set until reset.
                    md_err_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        MdBusy = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    // Completion releases the pipeline in the same cycle.
                    if (!MdDoneE) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                        MdBusy = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign MdErr       = md_err_q;
    assign StallCycles = stall_cnt_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MD_MAX_CYCLES, default 34: maximum cycles the block waits for a multi-cycle execute op before timing out.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 Rs1D, Rs2D  in  5 each  source register indices in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  source and destination indices in Execute.
REQ-007 RdM, RdW  in  5 each  destination indices in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback.
REQ-009 ResultSrcE  in  2  result select in Execute; 2'b01 marks a load.
REQ-010 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-011 MdStartE, MdDoneE  in  1 each  multi-cycle op present in Execute, and its completion pulse.
REQ-012 StallF, StallD, StallE  out  1 each  hold the corresponding pipeline registers.
REQ-013 FlushD, FlushE, FlushM  out  1 each  bubble the corresponding pipeline registers.
REQ-014 ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-015 MdBusy  out  1  high while waiting for a multi-cycle op.
REQ-016 MdErr  out  1  sticky multi-cycle timeout flag.
REQ-017 StallCycles  out  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-018 ForwardAE SHALL be 10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; otherwise 01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; otherwise 00. Memory wins when both match. ForwardBE SHALL follow the same rule using Rs2E.
REQ-019 Forwarding SHALL be purely combinational (zero latency) and valid in every state.
REQ-020 Load-use stall: lwStall = (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-021 FSM states SHALL be RUN and MD_WAIT.
REQ-022 In RUN with lwStall=1 and PCSrcE=0: StallF=1, StallD=1, FlushE=1 for exactly that cycle.
REQ-023 In RUN with PCSrcE=1: FlushD=1, FlushE=1, StallF=0, StallD=0; PCSrcE overrides lwStall.
REQ-024 In RUN with MdStartE=1 and MdDoneE=0, the next state SHALL be MD_WAIT and the op counter SHALL clear to 0.
REQ-025 In RUN with MdStartE=1 and MdDoneE=1 (single-cycle completion), the state SHALL remain RUN and no stall SHALL be asserted.
REQ-026 In MD_WAIT: StallF=StallD=StallE=1, FlushM=1, MdBusy=1; the counter SHALL increment each cycle; PCSrcE and lwStall SHALL be ignored.
REQ-027 In MD_WAIT with MdDoneE=1: all stalls and FlushM SHALL deassert in that same cycle, and the next state SHALL be RUN.
REQ-028 In MD_WAIT, when the counter reaches MD_MAX_CYCLES-1 without MdDoneE: MdErr SHALL set, and the next state SHALL be RUN.
REQ-029 StallCycles SHALL increment on every cycle with StallF=1 and hold at all-ones without wrapping.
REQ-030 Outputs not named in a state SHALL be 0 in that state.

Reset
REQ-031 While rst=1: state=RUN, op counter=0, MdErr=0, StallCycles=0; StallF/D/E=0, FlushD=FlushE=FlushM=1, MdBusy=0.
REQ-032 Asserting rst during MD_WAIT SHALL abandon the op; the state SHALL be RUN on the first cycle after rst deasserts.
REQ-033 MdErr SHALL clear only on rst.

Structure
REQ-034 The state enum, the ForwardXE encodings (FWD_RF, FWD_WB, FWD_MEM), and the load encoding of ResultSrc SHALL live in a shared pipeline package.
REQ-035 Forwarding logic SHALL be one sub-module, forward_select, instantiated twice (A and B); the FSM and counters stay in the top module.

Verification
REQ-036 RdM=5 with RegWriteM=1, and RdW=5 with RegWriteW=1, Rs1E=5 -> ForwardAE=10. Repeat with RdM=0 -> ForwardAE=01.
REQ-037 ResultSrcE=01, RdE=7, Rs2D=7 -> one cycle of StallF=StallD=FlushE=1, and StallCycles goes 0->1. Repeat with RdE=0 -> no stall.
REQ-038 Load-use condition plus PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0.
REQ-039 MdStartE pulse, then MdDoneE 10 cycles later -> MdBusy high for 10 cycles, stalls drop in the done cycle, StallCycles=10.
REQ-040 MdStartE with no MdDoneE and MD_MAX_CYCLES=34 -> return to RUN after 34 cycles, MdErr=1 and sticky; a subsequent rst clears it.
REQ-041 rst asserted on the 3rd cycle of MD_WAIT -> Flush outputs=1 during rst, then RUN with MdBusy=0 and counters at 0.
